// File: rtl/fifo_uart_tx_if.sv
// FIFO read port seen by the UART drain stage: pop request, read data, empty flag.
// master = the reader (issues rd_en); slave = the FIFO side.
interface fifo_uart_tx_if;
   logic       rd_en;
   logic [7:0] buf_out;
   logic       buf_empty;

   modport master (output rd_en, input buf_out, input buf_empty);
   modport slave  (input rd_en, output buf_out, output buf_empty);
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one byte per frame and sends 8N1 (or 8P1/8P2), LSB first.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN (PARITY_ODD selects odd parity).
module fifo_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_enable,
   fifo_uart_tx_if.master        buf_if,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done,
   output logic [7:0]            frame_count
);

   localparam int unsigned     BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

   generate
      if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
          STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_param_check
         $error("fifo_uart_tx: illegal parameter value");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [BW-1:0]   baud_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            baud_tc;
   logic            rd_en_c;
   logic            done_c;
`ifdef UART_TX_PARITY_EN
   logic            par_bit;
`endif

   assign baud_tc      = (baud_cnt == BAUD_LAST);
   assign buf_if.rd_en = rd_en_c;
   assign frame_done   = done_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      rd_en_c    = 1'b0;
      done_c     = 1'b0;
      case (state)
         S_IDLE: begin
            if (tx_enable && !buf_if.buf_empty) begin
               rd_en_c    = 1'b1;
               state_next = S_LOAD;
            end
         end
         S_LOAD:  state_next = S_START;
         S_START: begin
            if (baud_tc) state_next = S_DATA;
         end
         S_DATA: begin
            if (baud_tc && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_next = S_PARITY;
`else
               state_next = S_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_tc) state_next = S_STOP;
         end
`endif
         S_STOP: begin
            if (baud_tc && bit_cnt == STOP_LAST) begin
               done_c     = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
      // Reset wins over everything, including a pending pop.
      if (rst) begin
         state_next = S_IDLE;
         rd_en_c    = 1'b0;
         done_c     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx          <= 1'b1;
         busy        <= 1'b0;
         baud_cnt    <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         frame_count <= '0;
`ifdef UART_TX_PARITY_EN
         par_bit     <= 1'b0;
`endif
      end else begin
         busy <= (state_next != S_IDLE);

         if (state == S_IDLE || state == S_LOAD || baud_tc) begin
            baud_cnt <= '0;
         end else begin
            baud_cnt <= baud_cnt + 1'b1;
         end

         case (state)
            S_IDLE: tx <= 1'b1;
            S_LOAD: begin
               shreg   <= buf_if.buf_out;
               bit_cnt <= '0;
               tx      <= 1'b0;
`ifdef UART_TX_PARITY_EN
               par_bit <= (^buf_if.buf_out) ^ 1'(PARITY_ODD);
`endif
            end
            S_START: begin
               if (baud_tc) begin
                  tx    <= shreg[0];
                  shreg <= shreg >> 1;
               end
            end
            S_DATA: begin
               if (baud_tc) begin
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                     tx      <= par_bit;
`else
                     tx      <= 1'b1;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (baud_tc) tx <= 1'b1;
            end
`endif
            S_STOP: begin
               if (baud_tc) begin
                  if (bit_cnt == STOP_LAST) begin
                     bit_cnt     <= '0;
                     frame_count <= frame_count + 8'd1;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            default: tx <= 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4; parity build uses STOP_BITS=2, even parity.
// Define UART_TX_PARITY_EN for both bench and RTL to exercise the parity variant.
module tb_fifo_uart_tx;

   localparam int unsigned C = 4;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned S        = 2;
   localparam int unsigned PAR      = 1;
   localparam int unsigned LAST_EXP = 49;
   localparam int unsigned GAP_EXP  = 50;
`else
   localparam int unsigned S        = 1;
   localparam int unsigned PAR      = 0;
   localparam int unsigned LAST_EXP = 41;
   localparam int unsigned GAP_EXP  = 42;
`endif
   localparam int unsigned FB   = 10 + S - 1 + PAR;
   localparam int unsigned LAST = 1 + FB * C;

   logic       clk;
   logic       rst;
   logic       tx_enable;
   logic       tx;
   logic       busy;
   logic       frame_done;
   logic [7:0] frame_count;

   fifo_uart_tx_if bif ();

   fifo_uart_tx #(
      .CLKS_PER_BIT (C),
      .STOP_BITS    (S),
      .PARITY_ODD   (0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_enable   (tx_enable),
      .buf_if      (bif),
      .tx          (tx),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_count (frame_count)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int pushed = 0;
   int pops   = 0;
   int fd_cnt = 0;
   int fd_cyc = 0;
   int n_last = 0;
   logic [7:0] mem [0:15];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bif.buf_empty = (pushed == pops);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bif.rd_en === 1'b1) begin
         bif.buf_out <= mem[pops];
         pops        <= pops + 1;
      end
      if (frame_done === 1'b1) begin
         fd_cnt <= fd_cnt + 1;
         fd_cyc <= cyc;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[pushed] = b;
      pushed++;
   endtask

   // Waits for the pop, then checks tx/busy/rd_en/frame_done every cycle of the frame.
   task automatic check_frame(input logic [7:0] b, input logic par, input int unsigned drop_at,
                              input logic [7:0] fc_exp, input string tag);
      int unsigned w = 0;
      int unsigned k;
      logic        exp_tx;
      while (bif.rd_en !== 1'b1 && w < 200) begin
         @(negedge clk);
         #1;
         w++;
      end
      chk({tag, " rd_en"}, 32'(bif.rd_en), 32'd1);
      n_last = cyc;
      chk({tag, " idle tx"}, 32'(tx), 32'd1);
      chk({tag, " idle busy"}, 32'(busy), 32'd0);
      for (int unsigned off = 1; off <= LAST; off++) begin
         @(negedge clk);
         if (off == drop_at) tx_enable = 1'b0;
         if (off == 1) begin
            exp_tx = 1'b1;
         end else begin
            k = (off - 2) / C;
            if (k == 0)                exp_tx = 1'b0;
            else if (k <= 8)           exp_tx = b[k-1];
            else if (PAR == 1 && k == 9) exp_tx = par;
            else                       exp_tx = 1'b1;
         end
         chk({tag, " tx"}, 32'(tx), 32'(exp_tx));
         chk({tag, " busy"}, 32'(busy), 32'd1);
         chk({tag, " rd_en low"}, 32'(bif.rd_en), 32'd0);
         chk({tag, " frame_done"}, 32'(frame_done), 32'(off == LAST));
      end
      @(negedge clk);
      chk({tag, " frame_count"}, 32'(frame_count), 32'(fc_exp));
      chk({tag, " busy after"}, 32'(busy), 32'd0);
      chk({tag, " tx after"}, 32'(tx), 32'd1);
   endtask

   int n1;
   int fd0;

   initial begin
      rst       = 1'b1;
      tx_enable = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("reset rd_en", 32'(bif.rd_en), 32'd0);
      end
      chk("reset tx", 32'(tx), 32'd1);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset frame_count", 32'(frame_count), 32'd0);
      rst = 1'b0;
      for (int unsigned i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle tx", 32'(tx), 32'd1);
         chk("idle busy", 32'(busy), 32'd0);
         chk("idle rd_en", 32'(bif.rd_en), 32'd0);
         chk("idle frame_count", 32'(frame_count), 32'd0);
         chk("idle frame_done", 32'(frame_done), 32'd0);
      end

      // Single byte 0xA5
      push(8'hA5);
      #1;
      check_frame(8'hA5, 1'b0, 0, 8'd1, "a5");
      chk("a5 done offset", 32'(fd_cyc - n_last), 32'(LAST_EXP));

      // Back-to-back 0x00, 0xFF
      push(8'h00);
      push(8'hFF);
      #1;
      check_frame(8'h00, 1'b0, 0, 8'd2, "b2b0");
      n1 = n_last;
      check_frame(8'hFF, 1'b0, 0, 8'd3, "b2b1");
      chk("b2b spacing", 32'(n_last - n1), 32'(GAP_EXP));
      for (int unsigned i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("b2b empty rd_en", 32'(bif.rd_en), 32'd0);
      end
      chk("b2b pops", 32'(pops), 32'd3);

      // tx_enable drops during DATA of 0x3C while 0x11 waits
      push(8'h3C);
      push(8'h11);
      #1;
      check_frame(8'h3C, 1'b0, 11, 8'd4, "dis");
      for (int unsigned i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("dis rd_en", 32'(bif.rd_en), 32'd0);
         chk("dis busy", 32'(busy), 32'd0);
      end
      chk("dis pops", 32'(pops), 32'd4);
      tx_enable = 1'b1;
      #1;
      check_frame(8'h11, 1'b0, 0, 8'd5, "en");

      // Reset during data bit 3 of 0x52 (bit 3 = 0), 0x81 queued behind it
      push(8'h52);
      push(8'h81);
      #1;
      chk("rstmid rd_en", 32'(bif.rd_en), 32'd1);
      repeat (19) @(negedge clk);
      chk("rstmid bit3", 32'(tx), 32'd0);
      fd0 = fd_cnt;
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid tx", 32'(tx), 32'd1);
      chk("rstmid busy", 32'(busy), 32'd0);
      chk("rstmid frame_count", 32'(frame_count), 32'd0);
      chk("rstmid frame_done", 32'(frame_done), 32'd0);
      chk("rstmid rd_en", 32'(bif.rd_en), 32'd0);
      @(negedge clk);
      chk("rstmid rd_en2", 32'(bif.rd_en), 32'd0);
      chk("rstmid pops", 32'(pops), 32'd6);
      chk("rstmid no done", 32'(fd_cnt), 32'(fd0));
      rst = 1'b0;
      #1;
      check_frame(8'h81, 1'b0, 0, 8'd1, "after_rst");

`ifdef UART_TX_PARITY_EN
      // 0x07 has three ones: even parity bit = 1
      push(8'h07);
      #1;
      check_frame(8'h07, 1'b1, 0, 8'd2, "par07");
      chk("par07 done offset", 32'(fd_cyc - n_last), 32'd49);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream drain stage for the 64-entry byte FIFO: pops bytes through the FIFO read port (rd_en / buf_out / buf_empty) and serialises each one as an asynchronous UART frame on tx.
- Frame format: 8N1 by default, LSB first, optional parity bit.
- Sits between the FIFO and the board-level serial pin. Owns FIFO read pacing: never reads faster than one byte per frame.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
- STOP_BITS, 1, number of stop bits; 1 or 2 only.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous and active-high.
- tx_enable  input  1  permits new frames to start; does not abort a frame in progress.
- buf_empty  input  1  FIFO empty flag.
- buf_out  input  8  FIFO read data; valid the cycle after the edge at which rd_en=1 was sampled.
- rd_en  output  1  FIFO pop request; combinational, one-cycle pulse.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  high whenever state != IDLE; registered.
- frame_done  output  1  one-cycle pulse in the last cycle of the final stop bit.
- frame_count  output  8  frames completed since reset; wraps 255 -> 0.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it is sampled only on posedge clk.
- Reset values: tx=1, busy=0, frame_done=0, frame_count=0, state=IDLE, all counters 0. rd_en is forced to 0 while rst=1.
- rd_en = (state==IDLE) && tx_enable && !buf_empty && !rst. No other state may assert rd_en.
- FSM transitions:
  - IDLE -> LOAD at the edge where rd_en=1.
  - LOAD: capture buf_out into an 8-bit shift register; clear the baud counter; tx<=0 at the edge leaving LOAD. LOAD -> START.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first. Each bit is held exactly CLKS_PER_BIT cycles. The 3-bit bit counter goes 0..7. After bit 7 -> PARITY if enabled, else STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done=1 in the final cycle of STOP; frame_count increments on that same edge. STOP -> IDLE.
- Latency: with rd_en=1 in cycle N, tx=0 during cycles N+2 .. N+1+CLKS_PER_BIT.
- Baud counter: $clog2(CLKS_PER_BIT) bits. Counts 0..CLKS_PER_BIT-1, advances the bit on terminal count, then reloads to 0.
- Back-to-back frames: if the FIFO stays non-empty, the next rd_en occurs in the IDLE cycle right after STOP. The gap between frames is therefore exactly 2 extra idle-high cycles (IDLE + LOAD).
- buf_empty and tx_enable are sampled only in IDLE. Changes during START/DATA/STOP have no effect on the current frame.
- tx_enable falling mid-frame: the current frame completes normally; the FSM then stays in IDLE.
- rst asserted mid-frame: at the next edge tx=1 and state=IDLE. The shift register contents are discarded; the popped byte is lost, by design. frame_count is cleared.
- rst coincident with rd_en conditions: rd_en stays 0, so no byte is popped.
- busy is high from the LOAD cycle through the last STOP cycle inclusive.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - tx = XOR of the 8 data bits when PARITY_ODD=0.
  - tx = inverted XOR when PARITY_ODD=1.
  - Parity is computed from the byte captured in LOAD.
  - Frame length is 11 + STOP_BITS - 1 bits.
- Not defined: no PARITY state and no parity logic. PARITY_ODD is ignored. Frame length is 10 + STOP_BITS - 1 bits.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, buf_empty=1, tx_enable=1 -> tx=1, busy=0, rd_en=0, frame_count=0 for 20 cycles.
- Single byte, CLKS_PER_BIT=4, parity off:
  - Stimulus: FIFO holds 0xA5, rd_en=1 in cycle N.
  - Required: tx=0 in cycles N+2..N+5; then data bits 1,0,1,0,0,1,0,1, each 4 cycles.
  - Then tx=1 for 4 cycles; frame_done pulses in cycle N+41; frame_count=1.
- Back-to-back: FIFO holds 0x00, 0xFF -> exactly two rd_en pulses 42 cycles apart, 2 idle cycles between frames, frame_count=2, buf_empty honoured afterwards (no third pop).
- Disable mid-frame: tx_enable=0 during DATA of 0x3C with 0x11 queued -> 0x3C completes; no rd_en until tx_enable=1, after which 0x11 is sent.
- Reset mid-frame: rst=1 during DATA bit 3 -> tx=1 at the next edge, busy=0, frame_count=0, no frame_done; the next queued byte starts cleanly after rst drops.
- Parity build (UART_TX_PARITY_EN, PARITY_ODD=0, STOP_BITS=2): byte 0x07 -> parity bit = 1, stop high for 8 cycles, frame 12 bits = 48 cycles.
